// File: rtl/md5_pkg.sv
// Shared constants, FSM state type and the digest salting helper for the MD5 engine.
// Latency: n/a (package). Backpressure: n/a.
// Contents: SALT_A..SALT_D, MD5_OPS, md5_state_e, digest_add().
package md5_pkg;

    localparam logic [31:0] SALT_A  = 32'h67452301;
    localparam logic [31:0] SALT_B  = 32'hefcdab89;
    localparam logic [31:0] SALT_C  = 32'h98badcfe;
    localparam logic [31:0] SALT_D  = 32'h10325476;
    localparam int          MD5_OPS = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINAL,
        DONE
    } md5_state_e;

    // Per-lane modulo-2^32 add of the salts onto the final working state;
    // each lane is a self-determined 32-bit sum so no carry crosses lanes.
    function automatic logic [127:0] digest_add(input logic [127:0] work);
        return {work[127:96] + SALT_A,
                work[95:64]  + SALT_B,
                work[63:32]  + SALT_C,
                work[31:0]   + SALT_D};
    endfunction

endpackage

// File: rtl/md5_operation.sv
// One MD5 round/phase step: mix function, message word select, constant add, rotate.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: round/phase select the op, msg is the padded block, cur_state -> next_state {A,B,C,D}.
module md5_operation (
    input  logic [1:0]   round,
    input  logic [3:0]   phase,
    input  logic [511:0] msg,
    input  logic [127:0] cur_state,
    output logic [127:0] next_state
);

    localparam logic [31:0] K_TABLE [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotate amounts indexed by {round, phase[1:0]}.
    localparam logic [4:0] S_TABLE [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    logic [31:0] a, b, c, d;
    logic [31:0] f, m_word, k_word, sum;
    logic [3:0]  g;
    logic [4:0]  s;
    logic [63:0] rot;

    always_comb begin
        a = cur_state[127:96];
        b = cur_state[95:64];
        c = cur_state[63:32];
        d = cur_state[31:0];
        f = '0;
        g = '0;
        // Word index arithmetic is deliberately 4-bit so it wraps mod 16.
        case (round)
            2'd0: begin f = (b & c) | (~b & d); g = phase;                end
            2'd1: begin f = (d & b) | (~d & c); g = phase * 4'd5 + 4'd1;  end
            2'd2: begin f = b ^ c ^ d;          g = phase * 4'd3 + 4'd5;  end
            default: begin f = c ^ (b | ~d);    g = phase * 4'd7;         end
        endcase
        s      = S_TABLE[{round, phase[1:0]}];
        // Word 0 is the most significant word of the block.
        m_word = msg[{4'd15 - g, 5'd0} +: 32];
        k_word = K_TABLE[{round, phase}];
        sum    = a + f + k_word + m_word;
        // Upper half of the doubled word shifted left is a left rotate.
        rot        = {sum, sum} << s;
        next_state = {d, b + rot[63:32], b, c};
    end

endmodule

// File: rtl/md5_digest_engine.sv
// Iterative MD5 digest of one 128-bit candidate, salted and compared against a target.
// Latency: result 64/UNROLL+1 cycles after accept; one job in flight at a time.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no bypass.
// Ports: clk/rst (async, active-high); in_valid/in_ready/in_message/in_target upstream;
//        out_valid/out_ready/out_message/out_digest/out_match downstream.
module md5_digest_engine
    import md5_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_message,
    input  logic [127:0] in_target,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_message,
    output logic [127:0] out_digest,
    output logic         out_match
);

    md5_state_e   state_q, state_d;
    logic [5:0]   cnt_q;
    logic [511:0] msg_q;
    logic [127:0] target_q;
    logic [127:0] work_q;
    logic [127:0] digest;
    logic         accept;
    logic         last_step;
    logic [127:0] chain [UNROLL+1];

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q == 6'(MD5_OPS - UNROLL));
    assign digest    = digest_add(work_q);
    assign chain[0]  = work_q;

    // UNROLL operations per cycle; stage i runs op index cnt+i.
    for (genvar i = 0; i < UNROLL; i++) begin : g_stage
        logic [5:0] op_idx;
        assign op_idx = cnt_q + 6'(i);
        md5_operation u_op (
            .round      (op_idx[5:4]),
            .phase      (op_idx[3:0]),
            .msg        (msg_q),
            .cur_state  (chain[i]),
            .next_state (chain[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_step) state_d = FINAL;
            FINAL:                  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            msg_q       <= '0;
            target_q    <= '0;
            work_q      <= '0;
            out_valid   <= 1'b0;
            out_match   <= 1'b0;
            out_digest  <= '0;
            out_message <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        msg_q    <= {in_message, 384'b0};
                        target_q <= in_target;
                        work_q   <= {SALT_A, SALT_B, SALT_C, SALT_D};
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
                    work_q <= chain[UNROLL];
                    // Wraps to 0 on the last step.
                    cnt_q  <= cnt_q + 6'(UNROLL);
                end
                FINAL: begin
                    out_digest  <= digest;
                    out_match   <= (digest == target_q);
                    out_message <= msg_q[511:384];
                    out_valid   <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_digest_engine.sv
// Self-checking bench for md5_digest_engine with UNROLL=1 (index 0) and UNROLL=4 (index 1).
// Latency: n/a. Backpressure: exercised by holding out_ready low.
// Scoreboard pushes the expected result on each accept and pops it on the first out_valid cycle.
module tb_md5_digest_engine;

    localparam logic [31:0] SA = 32'h67452301;
    localparam logic [31:0] SB = 32'hefcdab89;
    localparam logic [31:0] SC = 32'h98badcfe;
    localparam logic [31:0] SD = 32'h10325476;

    localparam logic [31:0] KT [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int ST [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    typedef struct {
        logic [127:0] msg;
        logic [127:0] dig;
        logic         match;
        int           acc;
    } exp_t;

    typedef struct {
        logic [127:0] msg;
        logic [127:0] tgt;
        logic [127:0] dig;
        logic         match;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid    [2];
    logic         in_ready    [2];
    logic [127:0] in_message  [2];
    logic [127:0] in_target   [2];
    logic         out_valid   [2];
    logic         out_ready   [2];
    logic [127:0] out_message [2];
    logic [127:0] out_digest  [2];
    logic         out_match   [2];

    int           n_checks = 0;
    int           n_pass   = 0;
    int           cyc      = 0;
    exp_t         sbq0 [$];
    exp_t         sbq1 [$];
    bit           seen     [2];
    bit           prev_hs  [2];
    int           acc_cnt  [2];
    int           last_acc [2];
    logic [127:0] cap_dig  [2];
    logic [127:0] cap_msg  [2];
    logic         cap_match[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    md5_digest_engine #(.UNROLL(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_message(in_message[0]), .in_target(in_target[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_message(out_message[0]), .out_digest(out_digest[0]), .out_match(out_match[0])
    );

    md5_digest_engine #(.UNROLL(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_message(in_message[1]), .in_target(in_target[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_message(out_message[1]), .out_digest(out_digest[1]), .out_match(out_match[1])
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    // Reference model: 64 steps on word-big-endian block {m, 384'b0}, state seeded with the salts.
    function automatic logic [127:0] golden(input logic [127:0] m);
        logic [31:0] w [16];
        logic [31:0] a, b, c, d, f, t;
        int g;
        for (int j = 0; j < 16; j++) w[j] = (j < 4) ? m[127 - 32*j -: 32] : 32'h0;
        a = SA; b = SB; c = SC; d = SD;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i;              end
                1:       begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7*i) % 16;     end
            endcase
            t = a + f + KT[i] + w[g];
            a = d;
            d = c;
            c = b;
            b = b + rotl(t, ST[(i/16)*4 + i%4]);
        end
        return {a + SA, b + SB, c + SC, d + SD};
    endfunction

    function automatic string nm(input string s, input int k);
        return $sformatf("%s_u%0d", s, (k == 0) ? 1 : 4);
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? sbq0.size() : sbq1.size();
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic mon(input int k);
        exp_t e;
        int   lat_exp;
        lat_exp = (k == 0) ? 65 : 17;
        if (rst) begin
            seen[k]    = 1'b0;
            prev_hs[k] = 1'b0;
        end else begin
            if (prev_hs[k]) begin
                chk(nm("valid_after_hs", k), 128'(out_valid[k]), 128'(0));
                chk(nm("in_ready_after_hs", k), 128'(in_ready[k]), 128'(1));
            end
            if (in_valid[k] && in_ready[k]) begin
                e.msg   = in_message[k];
                e.dig   = golden(in_message[k]);
                e.match = (e.dig == in_target[k]);
                e.acc   = cyc + 1;
                if (k == 0) sbq0.push_back(e);
                else        sbq1.push_back(e);
                acc_cnt[k]++;
                last_acc[k] = cyc + 1;
            end
            if (out_valid[k]) begin
                chk(nm("in_ready_busy", k), 128'(in_ready[k]), 128'(0));
                if (!seen[k]) begin
                    chk(nm("sb_entry", k), 128'(qsize(k) != 0), 128'(1));
                    if (qsize(k) != 0) begin
                        if (k == 0) e = sbq0.pop_front();
                        else        e = sbq1.pop_front();
                        chk(nm("latency", k), 128'(cyc - e.acc), 128'(lat_exp));
                        chk(nm("digest", k), out_digest[k], e.dig);
                        chk(nm("match", k), 128'(out_match[k]), 128'(e.match));
                        chk(nm("message", k), out_message[k], e.msg);
                    end
                    cap_dig[k]   = out_digest[k];
                    cap_msg[k]   = out_message[k];
                    cap_match[k] = out_match[k];
                    seen[k]      = 1'b1;
                end else begin
                    chk(nm("stable_digest", k), out_digest[k], cap_dig[k]);
                    chk(nm("stable_message", k), out_message[k], cap_msg[k]);
                    chk(nm("stable_match", k), 128'(out_match[k]), 128'(cap_match[k]));
                end
            end else begin
                seen[k] = 1'b0;
            end
            prev_hs[k] = out_valid[k] && out_ready[k];
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Called and returns at posedge+1.
    task automatic submit(input int k, input logic [127:0] m, input logic [127:0] t);
        int base;
        bit ok;
        base = acc_cnt[k];
        ok   = 1'b0;
        in_valid[k]   = 1'b1;
        in_message[k] = m;
        in_target[k]  = t;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(posedge clk); #1;
            if (acc_cnt[k] != base) ok = 1'b1;
        end
        in_valid[k] = 1'b0;
        chk(nm("accepted", k), 128'(ok), 128'(1));
    endtask

    task automatic wait_done(input int k, input bit scramble);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(posedge clk); #1;
            if (qsize(k) == 0 && !out_valid[k]) ok = 1'b1;
            else if (scramble) begin
                in_message[k] = {$urandom, $urandom, $urandom, $urandom};
                in_target[k]  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        chk(nm("done_in_time", k), 128'(ok), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t         vt [4];
        logic [127:0] cand [3];
        logic [127:0] ctgt [3];
        int           acc_at [3];
        int           base;
        bit           ok;
        bit           abort_seen;
        logic [127:0] m;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b1;
            in_message[k] = '0; in_target[k] = '0;
            seen[k] = 1'b0; prev_hs[k] = 1'b0; acc_cnt[k] = 0; last_acc[k] = 0;
        end

        vt[0].msg = 128'h0;
        vt[0].dig = golden(vt[0].msg); vt[0].tgt = vt[0].dig; vt[0].match = 1'b1;
        vt[1].msg = 128'h0123456789abcdeffedcba9876543210;
        vt[1].dig = golden(vt[1].msg); vt[1].tgt = 128'h0; vt[1].match = 1'b0;
        vt[2].msg = {128{1'b1}};
        vt[2].dig = golden(vt[2].msg); vt[2].tgt = vt[2].dig; vt[2].match = 1'b1;
        vt[3].msg = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
        vt[3].dig = golden(vt[3].msg); vt[3].tgt = vt[3].dig ^ 128'h1; vt[3].match = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk(nm("rst_out_valid", k), 128'(out_valid[k]), 128'(0));
            chk(nm("rst_out_match", k), 128'(out_match[k]), 128'(0));
            chk(nm("rst_out_digest", k), out_digest[k], 128'(0));
            chk(nm("rst_out_message", k), out_message[k], 128'(0));
            chk(nm("rst_in_ready", k), 128'(in_ready[k]), 128'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk(nm("idle_in_ready", k), 128'(in_ready[k]), 128'(1));
        @(posedge clk); #1;

        // Table of vectors on both unroll factors.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                submit(k, vt[i].msg, vt[i].tgt);
                wait_done(k, 1'b0);
                chk(nm($sformatf("vec%0d_digest", i), k), cap_dig[k], vt[i].dig);
                chk(nm($sformatf("vec%0d_match", i), k), 128'(cap_match[k]), 128'(vt[i].match));
                chk(nm($sformatf("vec%0d_message", i), k), cap_msg[k], vt[i].msg);
            end
        end

        // Back-pressure: hold the result for 10 cycles.
        m = 128'h5555aaaa_0000ffff_13579bdf_2468ace0;
        out_ready[0] = 1'b0;
        submit(0, m, golden(m));
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(posedge clk); #1;
            if (out_valid[0]) ok = 1'b1;
        end
        chk("bp_valid_seen", 128'(ok), 128'(1));
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", 128'(out_valid[0]), 128'(1));
            chk("bp_in_ready_low", 128'(in_ready[0]), 128'(0));
        end
        out_ready[0] = 1'b1;
        wait_done(0, 1'b0);
        chk("bp_digest", cap_dig[0], golden(m));

        // in_valid held across three jobs: accept, 64 RUN, FINAL, DONE handshake, then the
        // next IDLE accept edge puts consecutive accepts 67 edges apart.
        cand[0] = 128'h1; cand[1] = 128'h2; cand[2] = 128'hffff0000_ffff0000_ffff0000_ffff0000;
        ctgt[0] = golden(cand[0]); ctgt[1] = 128'h0; ctgt[2] = golden(cand[2]);
        base = acc_cnt[0];
        for (int j = 0; j < 3; j++) begin
            in_valid[0] = 1'b1; in_message[0] = cand[j]; in_target[0] = ctgt[j];
            ok = 1'b0;
            for (int n = 0; n < 300 && !ok; n++) begin
                @(posedge clk); #1;
                if (acc_cnt[0] == base + j + 1) ok = 1'b1;
            end
            chk($sformatf("held_accept%0d", j), 128'(ok), 128'(1));
            acc_at[j] = last_acc[0];
        end
        in_valid[0] = 1'b0;
        wait_done(0, 1'b0);
        chk("held_spacing01", 128'(acc_at[1] - acc_at[0]), 128'(67));
        chk("held_spacing12", 128'(acc_at[2] - acc_at[1]), 128'(67));
        chk("held_last_match", 128'(cap_match[0]), 128'(1));

        // Reset mid-RUN drops the job; the resubmitted one completes normally.
        m = 128'h0badc0de_0badc0de_0badc0de_0badc0de;
        submit(0, m, golden(m));
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        sbq0.delete();
        sbq1.delete();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk(nm("midrst_out_valid", k), 128'(out_valid[k]), 128'(0));
            chk(nm("midrst_out_match", k), 128'(out_match[k]), 128'(0));
            chk(nm("midrst_out_digest", k), out_digest[k], 128'(0));
            chk(nm("midrst_out_message", k), out_message[k], 128'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        abort_seen = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk); #1;
            if (out_valid[0]) abort_seen = 1'b1;
        end
        chk("abort_no_output", 128'(abort_seen), 128'(0));
        submit(0, m, golden(m));
        wait_done(0, 1'b0);
        chk("resubmit_digest", cap_dig[0], golden(m));
        chk("resubmit_match", 128'(cap_match[0]), 128'(1));

        // Inputs churn every cycle after acceptance; only the sampled values count.
        m = 128'hfeedface_00c0ffee_a5a5a5a5_5a5a5a5a;
        submit(1, m, golden(m));
        wait_done(1, 1'b1);
        chk("churn_digest", cap_dig[1], golden(m));
        chk("churn_message", cap_msg[1], m);
        chk("churn_match", 128'(cap_match[1]), 128'(1));

        chk("sb_drained", 128'(qsize(0) + qsize(1)), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
